// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 beam counters with syncs, blanking, line/frame strobes and a frame counter.
// Latency: every output is registered and aligned to the hpos/vpos it is presented with.
// Backpressure: none; ena_i=0 freezes all state and clears the strobes on the next edge.
module vga_timing_gen #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   FRAME_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_i,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // Compare thresholds carry one spare bit so an end bound of 1024 still fits.
  localparam logic [10:0] H_DISP_END = 11'(H_DISPLAY);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_DISP_END = 11'(V_DISPLAY);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        de_nxt;

  // Next beam position and the decodes of that position, so registered outputs line up with it.
  always_comb begin
    h_wrap = (hpos == H_LAST);
    v_wrap = (vpos == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
    v_nxt  = vpos;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
    end
    h_ext  = {1'b0, h_nxt};
    v_ext  = {1'b0, v_nxt};
    hs_nxt = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    vs_nxt = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    de_nxt = (h_ext < H_DISP_END) && (v_ext < V_DISP_END);
  end

  // Reset parks the beam on the last pixel so the first enabled edge enters (0,0) as a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '1;
    end else if (ena_i) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      display_on  <= de_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end else begin
      // Frozen: everything holds except the strobes, which must never stretch.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing stage at the head of the VGA demo pipeline, running on the pixel clock (25.175 MHz nominal).
- Produces registered beam coordinates, sync pulses and blanking for 640x480@60.
- Also produces per-line and per-frame strobes and a frame counter, so downstream pattern generators need no frame-detect logic of their own.
- Feeds the RGB222 pattern stage that drives the Tiny VGA PMOD.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- FRAME_W, 10, frame_cnt width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- ena_i  in  1  advance enable; low freezes the block
- hpos  out  10  horizontal position, 0..H_TOTAL-1
- vpos  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_ACTIVE
- vsync  out  1  vertical sync, level per SYNC_ACTIVE
- display_on  out  1  high inside the visible area
- line_start  out  1  one-cycle strobe on entry to hpos==0
- frame_start  out  1  one-cycle strobe on entry to (0,0)
- frame_cnt  out  FRAME_W  completed-frame counter

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registered. Sync, display_on and strobes are computed from the next counter values, so every output is aligned with the hpos/vpos value in the same cycle. Zero cycles of skew between outputs.
- Reset (async assert, sync release by the system):
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1.
  - hsync, vsync = inactive (~SYNC_ACTIVE); display_on = 0; line_start = 0; frame_start = 0.
  - frame_cnt = all ones.
  - The first enabled edge after reset therefore enters (0,0), raises frame_start and wraps frame_cnt to 0.
- Counting, on each edge with ena_i=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0.
  - vpos increments only when hpos wraps; at V_TOTAL-1 with hpos wrap, vpos wraps to 0.
  - frame_cnt increments (modulo 2^FRAME_W) on the same edge that enters (0,0).
- hsync is asserted iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync is asserted iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), for the full line width.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- line_start = 1 only in the cycle immediately after an enabled edge that moved hpos to 0. frame_start follows the same rule for the move to (0,0). frame_start implies line_start.
- ena_i=0:
  - Counters, syncs, display_on and frame_cnt hold their values.
  - line_start and frame_start drop to 0 on the next edge. A strobe is never longer than one cycle, even if the freeze begins on a strobe cycle.
- Reset mid-frame: all outputs return to reset values immediately, regardless of clk. There is no partial-line output.
- Arithmetic:
  - Compare widths are sized for the parameter values.
  - hpos/vpos are exactly 10 bits; parameters yielding totals > 1024 are unsupported.

Test Plan:
- Reset release, ena_i=1 -> first edge: hpos=0, vpos=0, frame_start=1, line_start=1, frame_cnt=0, display_on=1. Next edge: hpos=1, both strobes 0.
- Run one line -> line period 800 cycles; hsync low for exactly 96 cycles, from hpos=656 through 751; display_on high for 640 cycles per visible line.
- Run one full frame -> frame_start period 420000 cycles; vsync low for 1600 cycles starting at (0,490); 307200 display_on cycles per frame; frame_cnt goes 0 -> 1.
- Hold ena_i=0 for 5 cycles at hpos=0 after a line_start -> hpos/vpos frozen; line_start high 1 cycle only; resume continues at hpos=1.
- Assert rst_n=0 asynchronously at (300,200) -> outputs reach reset values (799,524), display_on=0, syncs high, frame_cnt all ones, without a clock edge.
- Run 2^FRAME_W frames (FRAME_W=3 override) -> frame_cnt sequence 0..7,0, with the wrap on frame_start.
